// File: rtl/avmm_arbiter_2to1_if.sv
// avmm_arbiter_2to1_if: bundle of every bus signal around the 2:1 AVMM arbiter.
//
// Signal groups:
//   h0_* / h1_*  host ports: addr, read, write, wdata, byteen in;
//                waitrq, rdvalid, rdata, response out (from the arbiter's view)
//   tgt_*        target port: addr, read, write, wdata, byteen out;
//                rdvalid, wrvalid, rdata, response in (from the arbiter's view)
//   arb_owner    one-hot current owner, 00 when idle
//
// Modports:
//   slave   used by the arbiter itself
//   master  used by the surrounding hosts and target (all directions reversed)
interface avmm_arbiter_2to1_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] h0_addr;
  logic              h0_read;
  logic              h0_write;
  logic [DATA_W-1:0] h0_wdata;
  logic [3:0]        h0_byteen;
  logic              h0_waitrq;
  logic              h0_rdvalid;
  logic [DATA_W-1:0] h0_rdata;
  logic [1:0]        h0_response;

  logic [ADDR_W-1:0] h1_addr;
  logic              h1_read;
  logic              h1_write;
  logic [DATA_W-1:0] h1_wdata;
  logic [3:0]        h1_byteen;
  logic              h1_waitrq;
  logic              h1_rdvalid;
  logic [DATA_W-1:0] h1_rdata;
  logic [1:0]        h1_response;

  logic [ADDR_W-1:0] tgt_addr;
  logic              tgt_read;
  logic              tgt_write;
  logic [DATA_W-1:0] tgt_wdata;
  logic [3:0]        tgt_byteen;
  logic              tgt_rdvalid;
  logic              tgt_wrvalid;
  logic [DATA_W-1:0] tgt_rdata;
  logic [1:0]        tgt_response;

  logic [1:0]        arb_owner;

  modport slave (
    input  h0_addr, h0_read, h0_write, h0_wdata, h0_byteen,
    output h0_waitrq, h0_rdvalid, h0_rdata, h0_response,
    input  h1_addr, h1_read, h1_write, h1_wdata, h1_byteen,
    output h1_waitrq, h1_rdvalid, h1_rdata, h1_response,
    output tgt_addr, tgt_read, tgt_write, tgt_wdata, tgt_byteen,
    input  tgt_rdvalid, tgt_wrvalid, tgt_rdata, tgt_response,
    output arb_owner
  );

  modport master (
    output h0_addr, h0_read, h0_write, h0_wdata, h0_byteen,
    input  h0_waitrq, h0_rdvalid, h0_rdata, h0_response,
    output h1_addr, h1_read, h1_write, h1_wdata, h1_byteen,
    input  h1_waitrq, h1_rdvalid, h1_rdata, h1_response,
    input  tgt_addr, tgt_read, tgt_write, tgt_wdata, tgt_byteen,
    output tgt_rdvalid, tgt_wrvalid, tgt_rdata, tgt_response,
    input  arb_owner
  );
endinterface

// File: rtl/avmm_arbiter_2to1.sv
// avmm_arbiter_2to1: shares one AVMM CSR target between two AVMM hosts.
//
// Round-robin arbitration with a single outstanding transaction. The granted
// command is latched, strobed to the target for one cycle (ISSUE), held while
// waiting for tgt_rdvalid/tgt_wrvalid (WAIT), and the result is returned to
// the owning host in a one-cycle DONE state where its waitrq drops.
//
// Ports:
//   clk   single clock
//   rst   asynchronous, active-high reset
//   bus   avmm_arbiter_2to1_if.slave: h0_*, h1_* host ports, tgt_* target
//         port, arb_owner (one-hot owner, 00 when idle)
//
// Optional feature: define AVMM_ARB_TIMEOUT_EN to add a completion watchdog.
// After TIMEOUT_CYCLES clocks in WAIT without completion the transaction ends
// with response 2'b11 and, for reads, rdata 32'hDEAD_0A0B. Without the macro
// a target that never completes stalls the arbiter until rst.
module avmm_arbiter_2to1 #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                rst,
  avmm_arbiter_2to1_if.slave bus
);

  localparam logic [DATA_W-1:0] TimeoutRdata  = DATA_W'(32'hDEAD_0A0B);
  localparam logic [1:0]        RespDecodeErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;              // host index with priority
  logic              owner_q, owner_d;          // host index of current grant
  logic              owner_vld_q, owner_vld_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        byteen_q, byteen_d;
  logic [DATA_W-1:0] h0_rdata_q, h0_rdata_d;
  logic [DATA_W-1:0] h1_rdata_q, h1_rdata_d;
  logic [1:0]        h0_resp_q, h0_resp_d;
  logic [1:0]        h1_resp_q, h1_resp_d;

  logic              req0, req1, grant1;
  logic              cpl, timeout_hit;
  logic [1:0]        cap_resp;
  logic [DATA_W-1:0] cap_rdata;

  assign req0   = bus.h0_read | bus.h0_write;
  assign req1   = bus.h1_read | bus.h1_write;
  // host1 wins when it is the only requester or when it holds priority
  assign grant1 = req1 & (~req0 | ptr_q);

`ifdef AVMM_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StIssue) begin
      wait_cnt_d = '0;
    end else if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Fires in the last permitted WAIT cycle; a completion in that cycle wins.
  assign timeout_hit = (state_q == StWait) && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byteen_d    = byteen_q;
    h0_rdata_d  = h0_rdata_q;
    h1_rdata_d  = h1_rdata_q;
    h0_resp_d   = h0_resp_q;
    h1_resp_d   = h1_resp_q;
    cpl         = 1'b0;
    cap_resp    = '0;
    cap_rdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d     = grant1;
          owner_vld_d = 1'b1;
          // write has precedence when read and write are both asserted
          if (grant1) begin
            addr_d     = bus.h1_addr;
            wdata_d    = bus.h1_wdata;
            byteen_d   = bus.h1_byteen;
            op_write_d = bus.h1_write;
          end else begin
            addr_d     = bus.h0_addr;
            wdata_d    = bus.h0_wdata;
            byteen_d   = bus.h0_byteen;
            op_write_d = bus.h0_write;
          end
          state_d = StIssue;
        end
      end

      StIssue: begin
        // completions seen here belong to nothing we issued; ignore them
        state_d = StWait;
      end

      StWait: begin
        cpl = op_write_q ? bus.tgt_wrvalid : bus.tgt_rdvalid;
        if (cpl || timeout_hit) begin
          cap_resp  = cpl ? bus.tgt_response : RespDecodeErr;
          cap_rdata = cpl ? bus.tgt_rdata : TimeoutRdata;
          if (owner_q) begin
            h1_resp_d = cap_resp;
            if (!op_write_q) begin
              h1_rdata_d = cap_rdata;
            end
          end else begin
            h0_resp_d = cap_resp;
            if (!op_write_q) begin
              h0_rdata_d = cap_rdata;
            end
          end
          state_d = StDone;
        end
      end

      StDone: begin
        ptr_d       = ~owner_q;
        owner_vld_d = 1'b0;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      owner_vld_q <= 1'b0;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      byteen_q    <= '0;
      h0_rdata_q  <= '0;
      h1_rdata_q  <= '0;
      h0_resp_q   <= '0;
      h1_resp_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byteen_q    <= byteen_d;
      h0_rdata_q  <= h0_rdata_d;
      h1_rdata_q  <= h1_rdata_d;
      h0_resp_q   <= h0_resp_d;
      h1_resp_q   <= h1_resp_d;
    end
  end

  logic done;
  assign done = (state_q == StDone);

  assign bus.tgt_addr   = addr_q;
  assign bus.tgt_wdata  = wdata_q;
  assign bus.tgt_byteen = byteen_q;
  assign bus.tgt_read   = (state_q == StIssue) & ~op_write_q;
  assign bus.tgt_write  = (state_q == StIssue) & op_write_q;

  assign bus.h0_waitrq   = ~(done & ~owner_q);
  assign bus.h1_waitrq   = ~(done & owner_q);
  assign bus.h0_rdvalid  = done & ~owner_q & ~op_write_q;
  assign bus.h1_rdvalid  = done & owner_q & ~op_write_q;
  assign bus.h0_rdata    = h0_rdata_q;
  assign bus.h1_rdata    = h1_rdata_q;
  assign bus.h0_response = h0_resp_q;
  assign bus.h1_response = h1_resp_q;

  assign bus.arb_owner = owner_vld_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_avmm_arbiter_2to1.sv
// Bench for avmm_arbiter_2to1: a 16-register target model answering one cycle
// after each strobe (no answer at all for partial byte enables), a table of
// single-host transactions, and hand-written reset, latency, contention and
// watchdog sequences. Expected completions go into a queue when a request is
// driven and are popped when the host sees waitrq low.
module tb_avmm_arbiter_2to1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avmm_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  avmm_arbiter_2to1 #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0;
  int last_lat = 0;
  bit h_act [2];

  // ---------------- target model ----------------
  logic [31:0] mem [16] = '{default: 32'h0};

  always @(posedge clk) begin
    bus.tgt_rdvalid <= 1'b0;
    bus.tgt_wrvalid <= 1'b0;
    if ((bus.tgt_read || bus.tgt_write) && bus.tgt_byteen == 4'hF) begin
      if (bus.tgt_addr < 32'h40) begin
        bus.tgt_response <= 2'b00;
        if (bus.tgt_write) begin
          mem[bus.tgt_addr[5:2]] <= bus.tgt_wdata;
          bus.tgt_rdata          <= 32'h5EED_0000;
        end else begin
          bus.tgt_rdata <= mem[bus.tgt_addr[5:2]];
        end
      end else begin
        bus.tgt_response <= 2'b01;
        bus.tgt_rdata    <= 32'hBAD0_0000;
      end
      bus.tgt_rdvalid <= bus.tgt_read;
      bus.tgt_wrvalid <= bus.tgt_write;
    end
  end

  always @(negedge clk) begin
    if (bus.tgt_read || bus.tgt_write) n_strobe <= n_strobe + 1;
  end

  // ---------------- helpers ----------------
  typedef struct {
    int          host;
    logic        rd;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb [$];

  typedef struct {
    int          host;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int h, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (h == 0) begin
      bus.h0_read = rd; bus.h0_write = wr; bus.h0_addr = a; bus.h0_wdata = wd; bus.h0_byteen = be;
    end else begin
      bus.h1_read = rd; bus.h1_write = wr; bus.h1_addr = a; bus.h1_wdata = wd; bus.h1_byteen = be;
    end
    h_act[h] = 1'b1;
  endtask

  task automatic release_host(input int h);
    if (h == 0) begin
      bus.h0_read = 1'b0; bus.h0_write = 1'b0;
    end else begin
      bus.h1_read = 1'b0; bus.h1_write = 1'b0;
    end
    h_act[h] = 1'b0;
  endtask

  task automatic expect_done(input int h, input logic rd, input logic [31:0] rdata,
                             input logic [1:0] resp);
    exp_t e;
    e.host = h; e.rd = rd; e.rdata = rdata; e.resp = resp;
    sb.push_back(e);
  endtask

  task automatic complete(input int h);
    exp_t e;
    logic rv;
    logic [31:0] rd;
    logic [1:0] rs;
    rv = (h == 0) ? bus.h0_rdvalid : bus.h1_rdvalid;
    rd = (h == 0) ? bus.h0_rdata : bus.h1_rdata;
    rs = (h == 0) ? bus.h0_response : bus.h1_response;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_empty: host %0d completed, expected no completion", h);
    end else begin
      e = sb.pop_front();
      check("done_host", h, e.host);
      check("rdvalid", 32'(rv), 32'(e.rd));
      check("rdata", rd, e.rdata);
      check("response", 32'(rs), 32'(e.resp));
    end
    release_host(h);
  endtask

  // Step negedges until every active host has completed (bounded).
  task automatic service(input int budget);
    int cyc = 0;
    while ((h_act[0] || h_act[1]) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!bus.h0_waitrq) begin
        if (h_act[0]) begin last_lat = cyc; complete(0); end
        else begin n_tests++; n_fail++; $display("FAIL spurious_done: host 0 waitrq 0, expected 1"); end
      end
      if (!bus.h1_waitrq) begin
        if (h_act[1]) begin last_lat = cyc; complete(1); end
        else begin n_tests++; n_fail++; $display("FAIL spurious_done: host 1 waitrq 0, expected 1"); end
      end
    end
    if (h_act[0] || h_act[1]) begin
      n_tests++; n_fail++;
      $display("FAIL service_timeout: hosts still waiting after %0d cycles, expected done", budget);
      release_host(0);
      release_host(1);
      sb.delete();
    end
    @(negedge clk);
    check("waitrq_rise", 32'({bus.h0_waitrq, bus.h1_waitrq}), 3);
    check("owner_idle", 32'(bus.arb_owner), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int lows;

    vt[0] = '{1, 1'b1, 1'b0, 32'h8,     32'h0,         32'hA5A5_0001, 2'b00};
    vt[1] = '{0, 1'b0, 1'b1, 32'h1_0000, 32'h1234_5678, 32'h0,         2'b01};
    vt[2] = '{1, 1'b0, 1'b1, 32'h3C,    32'hCAFE_F00D, 32'hA5A5_0001, 2'b00};
    vt[3] = '{0, 1'b1, 1'b0, 32'h3C,    32'h0,         32'hCAFE_F00D, 2'b00};
    vt[4] = '{0, 1'b1, 1'b1, 32'h4,     32'h5555_AAAA, 32'hCAFE_F00D, 2'b00};
    vt[5] = '{1, 1'b1, 1'b0, 32'h4,     32'h0,         32'h5555_AAAA, 2'b00};
    vt[6] = '{1, 1'b1, 1'b0, 32'h1_0000, 32'h0,        32'hBAD0_0000, 2'b01};
    vt[7] = '{0, 1'b0, 1'b1, 32'h0,     32'h1111_2222, 32'hCAFE_F00D, 2'b00};
    vt[8] = '{1, 1'b1, 1'b0, 32'h0,     32'h0,         32'h1111_2222, 2'b00};
    vt[9] = '{0, 1'b1, 1'b0, 32'h8,     32'h0,         32'hA5A5_0001, 2'b00};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    release_host(0);
    release_host(1);
    repeat (2) @(negedge clk);

    // reset values
    check("rst_tgt_read", 32'(bus.tgt_read), 0);
    check("rst_tgt_write", 32'(bus.tgt_write), 0);
    check("rst_tgt_addr", bus.tgt_addr, 0);
    check("rst_tgt_wdata", bus.tgt_wdata, 0);
    check("rst_tgt_byteen", 32'(bus.tgt_byteen), 0);
    check("rst_waitrq", 32'({bus.h0_waitrq, bus.h1_waitrq}), 3);
    check("rst_rdvalid", 32'({bus.h0_rdvalid, bus.h1_rdvalid}), 0);
    check("rst_h0_rdata", bus.h0_rdata, 0);
    check("rst_h1_rdata", bus.h1_rdata, 0);
    check("rst_resp", 32'({bus.h0_response, bus.h1_response}), 0);
    check("rst_owner", 32'(bus.arb_owner), 0);
    rst = 1'b0;

    // single write, cycle by cycle
    @(negedge clk);
    s0 = n_strobe;
    drive(0, 1'b0, 1'b1, 32'h8, 32'hA5A5_0001, 4'hF);
    @(negedge clk);
    check("issue_tgt_write", 32'(bus.tgt_write), 1);
    check("issue_tgt_read", 32'(bus.tgt_read), 0);
    check("issue_tgt_addr", bus.tgt_addr, 32'h8);
    check("issue_tgt_wdata", bus.tgt_wdata, 32'hA5A5_0001);
    check("issue_tgt_byteen", 32'(bus.tgt_byteen), 32'hF);
    check("issue_h0_waitrq", 32'(bus.h0_waitrq), 1);
    check("issue_owner", 32'(bus.arb_owner), 1);
    @(negedge clk);
    check("wait_tgt_write", 32'(bus.tgt_write), 0);
    check("wait_tgt_addr", bus.tgt_addr, 32'h8);
    check("wait_h0_waitrq", 32'(bus.h0_waitrq), 1);
    @(negedge clk);
    check("done_h0_waitrq", 32'(bus.h0_waitrq), 0);
    check("done_h0_rdvalid", 32'(bus.h0_rdvalid), 0);
    check("done_h0_resp", 32'(bus.h0_response), 0);
    check("done_h1_waitrq", 32'(bus.h1_waitrq), 1);
    release_host(0);
    @(negedge clk);
    check("after_h0_waitrq", 32'(bus.h0_waitrq), 1);
    check("after_owner", 32'(bus.arb_owner), 0);
    check("write_strobes", n_strobe - s0, 1);

    // table of single-host transactions
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s0 = n_strobe;
      drive(vt[i].host, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, 4'hF);
      expect_done(vt[i].host, vt[i].rd & ~vt[i].wr, vt[i].exp_rdata, vt[i].exp_resp);
      service(20);
      check("latency", last_lat, 3);
      check("one_strobe", n_strobe - s0, 1);
    end

    // contention from reset: host0 first, then host1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s0 = n_strobe;
    drive(0, 1'b1, 1'b0, 32'h3C, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
    expect_done(0, 1'b1, 32'hCAFE_F00D, 2'b00);
    expect_done(1, 1'b1, 32'hA5A5_0001, 2'b00);
    service(40);
    check("contend1_strobes", n_strobe - s0, 2);

    // lone host0 read leaves priority with host1
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    expect_done(0, 1'b1, 32'h1111_2222, 2'b00);
    service(20);

    s0 = n_strobe;
    drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h3C, 32'h0, 4'hF);
    expect_done(1, 1'b1, 32'hCAFE_F00D, 2'b00);
    expect_done(0, 1'b1, 32'h5555_AAAA, 2'b00);
    service(40);
    check("contend2_strobes", n_strobe - s0, 2);

    // reset while waiting on a target that never answers
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h3C, 32'h0, 4'b0011);
    repeat (3) @(negedge clk);
    check("hang_owner", 32'(bus.arb_owner), 1);
    check("hang_waitrq", 32'(bus.h0_waitrq), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_strobes", 32'({bus.tgt_read, bus.tgt_write}), 0);
    check("midrst_waitrq", 32'({bus.h0_waitrq, bus.h1_waitrq}), 3);
    check("midrst_owner", 32'(bus.arb_owner), 0);
    release_host(0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.h0_waitrq || !bus.h1_waitrq || bus.h0_rdvalid) lows++;
    end
    check("midrst_no_completion", lows, 0);
    check("midrst_owner_after", 32'(bus.arb_owner), 0);

`ifdef AVMM_ARB_TIMEOUT_EN
    // watchdog: partial byteen read never completes at the target
    drive(0, 1'b1, 1'b0, 32'h3C, 32'h0, 4'b0011);
    expect_done(0, 1'b1, 32'hDEAD_0A0B, 2'b11);
    service(30);
    check("timeout_latency", last_lat, 10);
    drive(0, 1'b1, 1'b0, 32'h3C, 32'h0, 4'hF);
    expect_done(0, 1'b1, 32'hCAFE_F00D, 2'b00);
    service(20);
    check("post_timeout_latency", last_lat, 3);
`endif

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
